// File: rtl/fpga_send.sv
// fpga_send: buffers bytes from an internal producer and hands them to a
// Raspberry Pi one at a time over a GPIO byte bus, framed by send_start.
// Reset is synchronous and active-high even though the port is named rst_n.
module fpga_send #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              pi_clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              send_start,
  input  logic              pi_read,
  output logic [DATA_W-1:0] gpio_pin,
  output logic              tx_valid,
  output logic              frame_done,
  output logic              busy,
  output logic [5:0]        LED
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              accept;
  logic              consume;
  logic [2:0]        led_cnt;

  // Next-state, pointer/count bookkeeping and the GPIO-facing outputs.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    drop_d     = drop_q;
    consume    = 1'b0;
    tx_valid   = 1'b0;
    gpio_pin   = '0;
    frame_done = 1'b0;
    load_ready = (state_q == StIdle) && (count_q < CntW'(DEPTH));
    accept     = load_valid && load_ready;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    // A refused byte is lost; latch that for the debug LED until reset.
    if (load_valid && !load_ready) begin
      drop_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        // A byte accepted on the same edge as send_start joins the frame.
        if (send_start && ((count_q != '0) || accept)) begin
          state_d = StSend;
        end
      end
      StSend: begin
        tx_valid = 1'b1;
        gpio_pin = mem_q[rd_ptr_q];
        if (pi_read) begin
          consume  = 1'b1;
          rd_ptr_d = rd_ptr_q + PtrW'(1);
          if (count_q == CntW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Loads only happen in IDLE and reads only in SEND, so never both at once.
    count_d = count_q + CntW'(accept) - CntW'(consume);
  end

  // State, pointers, count and sticky drop flag; reset wins over everything.
  always_ff @(posedge pi_clk) begin
    if (rst_n) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Byte storage; contents need no reset since count gates every read.
  always_ff @(posedge pi_clk) begin
    if (!rst_n && accept) begin
      mem_q[wr_ptr_q] <= load_data;
    end
  end

  // Debug count on the LEDs saturates at 7 when the counter is wider than 3 bits.
  if (CntW > 3) begin : g_led_sat
    assign led_cnt = (count_q > CntW'(7)) ? 3'd7 : count_q[2:0];
  end else begin : g_led_ext
    assign led_cnt = 3'(count_q);
  end

  assign busy = (state_q != StIdle);
  assign LED  = {drop_q, state_q, led_cnt};

endmodule

// File: tb/tb_fpga_send.sv
// Directed self-checking bench for fpga_send (DEPTH=4, DATA_W=8).
module tb_fpga_send;

  logic       pi_clk;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       send_start;
  logic       pi_read;
  logic [7:0] gpio_pin;
  logic       tx_valid;
  logic       frame_done;
  logic       busy;
  logic [5:0] LED;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int fd_mark;

  fpga_send #(
    .DEPTH (4),
    .DATA_W(8)
  ) dut (
    .pi_clk    (pi_clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .send_start(send_start),
    .pi_read   (pi_read),
    .gpio_pin  (gpio_pin),
    .tx_valid  (tx_valid),
    .frame_done(frame_done),
    .busy      (busy),
    .LED       (LED)
  );

  initial pi_clk = 1'b0;
  always #5 pi_clk = ~pi_clk;

  // Count frame_done pulses as seen by the rising edge.
  always @(posedge pi_clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic tick();
    @(posedge pi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] led_exp(input logic drop, input logic [1:0] st,
                                         input logic [2:0] cnt);
    return {drop, st, cnt};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_gpio"}, 32'(gpio_pin), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    chk({tag, "_led"}, 32'(LED), 32'd0);
  endtask

  task automatic load_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] t1 [3];
    logic [7:0] t2 [4];
    t1 = '{8'h11, 8'h22, 8'h33};
    t2 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

    rst_n      = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    send_start = 1'b0;
    pi_read    = 1'b0;
    tick();
    tick();
    chk_reset_outputs("rst_init");
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("post_rst");

    // Three-byte frame, pi_read held high.
    for (int i = 0; i < 3; i++) load_byte(t1[i]);
    chk("t1_led_loaded", 32'(LED), 32'(led_exp(1'b0, 2'd0, 3'd3)));
    chk("t1_ready_loaded", 32'(load_ready), 32'd1);
    send_start = 1'b1;
    tick();
    send_start = 1'b0;
    chk("t1_tx_valid", 32'(tx_valid), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_send", 32'(load_ready), 32'd0);
    chk("t1_led_send", 32'(LED), 32'(led_exp(1'b0, 2'd1, 3'd3)));
    chk("t1_byte0", 32'(gpio_pin), 32'h11);
    pi_read = 1'b1;
    tick();
    chk("t1_byte1", 32'(gpio_pin), 32'h22);
    tick();
    chk("t1_byte2", 32'(gpio_pin), 32'h33);
    tick();
    chk("t1_done_pulse", 32'(frame_done), 32'd1);
    chk("t1_done_tx_valid", 32'(tx_valid), 32'd0);
    chk("t1_done_gpio", 32'(gpio_pin), 32'd0);
    chk("t1_led_done", 32'(LED), 32'(led_exp(1'b0, 2'd2, 3'd0)));
    tick();
    pi_read = 1'b0;
    chk("t1_done_cleared", 32'(frame_done), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_led", 32'(LED), 32'd0);

    // Fill the buffer, overflow by one byte, send the first four.
    for (int i = 0; i < 4; i++) load_byte(t2[i]);
    chk("t2_full_ready", 32'(load_ready), 32'd0);
    chk("t2_full_led", 32'(LED), 32'(led_exp(1'b0, 2'd0, 3'd4)));
    load_byte(8'hFF);
    chk("t2_drop_led", 32'(LED), 32'(led_exp(1'b1, 2'd0, 3'd4)));
    send_start = 1'b1;
    tick();
    send_start = 1'b0;
    pi_read    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_byte%0d", i), 32'(gpio_pin), 32'(t2[i]));
      tick();
    end
    pi_read = 1'b0;
    chk("t2_done_pulse", 32'(frame_done), 32'd1);
    tick();
    chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_idle_led", 32'(LED), 32'(led_exp(1'b1, 2'd0, 3'd0)));

    // send_start on an empty buffer is ignored.
    fd_mark    = fd_cnt;
    send_start = 1'b1;
    tick();
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_tx_valid", 32'(tx_valid), 32'd0);
    chk("t3_led_state", 32'(LED[4:3]), 32'd0);
    tick();
    send_start = 1'b0;
    tick();
    chk("t3_no_frame_done", 32'(fd_cnt - fd_mark), 32'd0);

    // Load and start on the same edge, then irregular pi_read.
    load_valid = 1'b1;
    load_data  = 8'hA5;
    send_start = 1'b1;
    tick();
    load_valid = 1'b0;
    send_start = 1'b0;
    chk("t4_tx_valid", 32'(tx_valid), 32'd1);
    chk("t4_byte", 32'(gpio_pin), 32'hA5);
    chk("t4_led", 32'(LED), 32'(led_exp(1'b1, 2'd1, 3'd1)));
    tick();
    chk("t4_hold1", 32'(gpio_pin), 32'hA5);
    tick();
    chk("t4_hold2", 32'(gpio_pin), 32'hA5);
    chk("t4_hold_valid", 32'(tx_valid), 32'd1);
    pi_read = 1'b1;
    tick();
    pi_read = 1'b0;
    chk("t4_done_pulse", 32'(frame_done), 32'd1);
    tick();
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // pi_read in IDLE must not consume; then reset mid-frame.
    pi_read = 1'b1;
    load_byte(8'h10);
    load_byte(8'h20);
    load_byte(8'h30);
    load_byte(8'h40);
    chk("t5_idle_read_ignored", 32'(LED), 32'(led_exp(1'b1, 2'd0, 3'd4)));
    pi_read    = 1'b0;
    send_start = 1'b1;
    tick();
    send_start = 1'b0;
    chk("t5_byte0", 32'(gpio_pin), 32'h10);
    pi_read = 1'b1;
    tick();
    tick();
    pi_read = 1'b0;
    chk("t5_byte2", 32'(gpio_pin), 32'h30);
    fd_mark = fd_cnt;
    rst_n   = 1'b1;
    tick();
    chk_reset_outputs("t5_rst");
    rst_n = 1'b0;
    tick();
    tick();
    chk("t5_no_frame_done", 32'(fd_cnt - fd_mark), 32'd0);
    chk_reset_outputs("t5_post_rst");
    load_byte(8'h01);
    load_byte(8'h02);
    send_start = 1'b1;
    tick();
    send_start = 1'b0;
    chk("t5_new_byte0", 32'(gpio_pin), 32'h01);
    pi_read = 1'b1;
    tick();
    chk("t5_new_byte1", 32'(gpio_pin), 32'h02);
    tick();
    pi_read = 1'b0;
    chk("t5_new_done", 32'(frame_done), 32'd1);
    tick();

    // Three back-to-back 3-byte frames across the pointer wrap.
    fd_mark = fd_cnt;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 3; i++) load_byte(8'((f + 1) * 16 + i));
      send_start = 1'b1;
      tick();
      send_start = 1'b0;
      pi_read    = 1'b1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t6_f%0d_byte%0d", f, i), 32'(gpio_pin), 32'((f + 1) * 16 + i));
        tick();
      end
      pi_read = 1'b0;
      chk($sformatf("t6_f%0d_done", f), 32'(frame_done), 32'd1);
      tick();
      chk($sformatf("t6_f%0d_idle", f), 32'(busy), 32'd0);
    end
    chk("t6_frame_done_count", 32'(fd_cnt - fd_mark), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
